interfaz_tx: RTL and testbench
==============================

# interfaz_tx

Transmit-side interface between the ALU result path and the UART transmitter. It captures each ALU result on the `i_data_ready` strobe into a small FIFO. It then drains the FIFO one byte at a time through the transmitter handshake: a one-cycle start pulse with the data held stable, then a wait for the transmitter's done pulse. It sits between the receive-side operand collector/ALU and the UART TX core, so results produced back-to-back are not lost while the serial line is busy.

## Interface
- `NB_DATA`, 8: width of result byte and TX data.
- `NB_ADDR`, 2: FIFO address width; depth = 2^NB_ADDR (4 by default).
- `i_clk`  in  1  system clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_data_ready`  in  1  one-cycle push strobe from the result path.
- `i_data`  in  NB_DATA  ALU result; sampled on edges where `i_data_ready`=1.
- `i_tx_done`  in  1  one-cycle pulse from the UART TX when the current byte has finished.
- `o_tx_start`  out  1  one-cycle request to the UART TX to begin sending `o_tx_data`.
- `o_tx_data`  out  NB_DATA  byte being transmitted; registered.
- `o_full`  out  1  FIFO count = depth.
- `o_empty`  out  1  FIFO count = 0.
- `o_overflow`  out  1  sticky flag: a push was dropped.

## Operation
- Reset values: FIFO read pointer, write pointer and count = 0; state IDLE; `o_tx_start`=0; `o_tx_data`=0; `o_overflow`=0; `o_empty`=1; `o_full`=0.
- FIFO: circular buffer with NB_ADDR-bit pointers that wrap modulo depth, and an NB_ADDR+1-bit count. `o_full` and `o_empty` are decoded from the registered count.
- Push: occurs when `i_data_ready`=1 and either count < depth or a pop occurs on the same edge. The write pointer increments.
- Dropped push: `i_data_ready`=1 with count = depth and no same-edge pop. The FIFO contents are unchanged and `o_overflow` is set; it stays set until reset.
- Pop: happens only as the IDLE→START transition. The head is loaded into `o_tx_data` and the read pointer increments.
- Simultaneous push and pop: count is unchanged and both pointers advance, including when full.
- State machine (2-bit):
  - IDLE: if count ≠ 0, pop and go to START; otherwise stay.
  - START: `o_tx_start`=1 for this cycle only; go to WAIT unconditionally.
  - WAIT: on `i_tx_done`=1 go to IDLE; otherwise stay. `o_tx_data` is held stable.
  - Unused encoding: go to IDLE with `o_tx_start`=0.
- `i_tx_done` in IDLE or START is ignored.
- `o_tx_data` keeps its last value after transmission, until the next pop.
- Reset during START or WAIT: everything returns to reset values immediately (asynchronous). Queued bytes are discarded. A late `i_tx_done` arriving in IDLE is ignored.

## Timing
- Let E0 be the edge that samples `i_data_ready`=1 into an empty FIFO while the machine is IDLE.
  - At E0: count becomes 1.
  - At E1: pop, `o_tx_data` loads, state becomes START.
  - Between E1 and E2: `o_tx_start`=1.
  - At E2: state becomes WAIT.
- Push to start latency is 1 cycle after the push edge (start pulse in the cycle following E1).
- `o_tx_data` is valid from E1 and stable through the whole WAIT state.
- After the edge that samples `i_tx_done` in WAIT:
  - the state is IDLE for 1 cycle;
  - if the FIFO is non-empty, the next `o_tx_start` follows after 1 more edge.
  - Minimum spacing between back-to-back starts is therefore 3 cycles plus the transmitter busy time.
- `o_full`, `o_empty` and `o_overflow` update on the same edge as the push or pop that causes them.

## Test plan
- **Single result:** push 0x5A while idle → `o_tx_data`=0x5A and `o_tx_start`=1 for exactly one cycle, 1 cycle after the push edge. Pulse `i_tx_done` → IDLE, `o_empty`=1.
- **Burst fill:** push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles with `i_tx_done` withheld.
  - 0x01 is popped; 0x02–0x05 fill the FIFO, so `o_full`=1 and `o_overflow`=0.
  - A sixth push of 0x06 → dropped and `o_overflow`=1.
  - After four `i_tx_done` pulses, the transmitted order is 0x01–0x05.
- **Push and pop on the same edge while full:** FIFO full and IDLE, push 0xAA on the pop edge → push accepted, count stays 4, `o_overflow` stays 0, and 0xAA is transmitted last.
- **Ignored done:** pulse `i_tx_done` while IDLE with the FIFO empty, and in START → no state change and no extra `o_tx_start`.
- **Reset mid-operation:** assert `i_reset` during WAIT with 2 bytes queued → all outputs at reset values asynchronously. After release, a stray `i_tx_done` produces no `o_tx_start`, and a new push of 0x3C is transmitted normally.
- **Pointer wrap-around:** push and transmit 10 sequential values 0x10–0x19 → all sent in order, with correct `o_empty` and `o_full` across the pointer wrap.

Source files
------------

// File: rtl/interfaz_tx.sv
//------------------------------------------------------------------------------
// Module      : interfaz_tx
// Description : Buffers ALU results in a small FIFO and feeds them one at a
//               time to the UART transmitter via a start/done handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module interfaz_tx #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_data_ready,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_overflow
);

    localparam int               C_DEPTH    = 1 << NB_ADDR;
    localparam logic [NB_ADDR:0] C_FULL_CNT = (NB_ADDR + 1)'(C_DEPTH);
    localparam logic [NB_ADDR:0] C_CNT_ONE  = (NB_ADDR + 1)'(1);
    localparam logic [NB_ADDR-1:0] C_PTR_ONE = NB_ADDR'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NB_ADDR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NB_ADDR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR:0]     count_q, count_d;
    logic                 tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 overflow_q, overflow_d;
    logic [NB_DATA-1:0]   mem_q [C_DEPTH];

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (count_q == C_FULL_CNT);
    // A pop frees a slot on the same edge, so a push into a full FIFO is
    // still accepted when the machine is popping.
    assign w_pop  = (state_q == ST_IDLE) && (count_q != '0);
    assign w_push = i_data_ready && (!w_full || w_pop);

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q;

        if (i_data_ready && !w_push) begin
            overflow_d = 1'b1;
        end
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + C_PTR_ONE;
            tx_data_d  = mem_q[rd_ptr_q];
            tx_start_d = 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_ONE;
            2'b01:   count_d = count_q - C_CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE:  state_d = w_pop ? ST_START : ST_IDLE;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  state_d = i_tx_done ? ST_IDLE : ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_full     = w_full;
    assign o_empty    = (count_q == '0);
    assign o_overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_interfaz_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_interfaz_tx
// Description : Self-checking bench for interfaz_tx with a queue-based model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_interfaz_tx;

    localparam int NB_DATA = 8;
    localparam int NB_ADDR = 2;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               i_reset;
    logic               i_data_ready;
    logic [NB_DATA-1:0] i_data;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_full;
    logic               o_empty;
    logic               o_overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents, transmitter phase (0 idle, 1 start,
    // 2 waiting for done), and the scoreboard of bytes still to appear.
    logic [NB_DATA-1:0] m_q[$];
    logic [NB_DATA-1:0] sb_q[$];
    int                 m_ph;
    logic               m_ovf;
    logic               m_start;
    logic [NB_DATA-1:0] m_data;

    interfaz_tx #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_data_ready (i_data_ready),
        .i_data       (i_data),
        .i_tx_done    (i_tx_done),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_overflow   (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        sb_q.delete();
        m_ph    = 0;
        m_ovf   = 1'b0;
        m_start = 1'b0;
        m_data  = '0;
    endtask

    task automatic model_step(input logic dr, input logic [NB_DATA-1:0] din, input logic done);
        logic pop;
        logic acc;
        pop = (m_ph == 0) && (m_q.size() != 0);
        acc = dr && ((m_q.size() < DEPTH) || pop);
        if (pop) m_data = m_q.pop_front();
        if (acc) begin
            m_q.push_back(din);
            sb_q.push_back(din);
        end else if (dr) begin
            m_ovf = 1'b1;
        end
        m_start = pop;
        case (m_ph)
            0:       m_ph = pop ? 1 : 0;
            1:       m_ph = 2;
            default: m_ph = done ? 0 : 2;
        endcase
    endtask

    task automatic check_outputs();
        chk("tx_start", 32'(o_tx_start), 32'(m_start));
        chk("tx_data",  32'(o_tx_data),  32'(m_data));
        chk("empty",    32'(o_empty),    32'(m_q.size() == 0));
        chk("full",     32'(o_full),     32'(m_q.size() == DEPTH));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    // Inputs change just after a falling edge; outputs are checked on the next one.
    task automatic cycle(input logic dr, input logic [NB_DATA-1:0] din, input logic done);
        i_data_ready = dr;
        i_data       = din;
        i_tx_done    = done;
        @(posedge clk);
        model_step(dr, din, done);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 500 && !(m_q.size() == 0 && m_ph == 0); k++) begin
            cycle(1'b0, '0, (m_ph == 2) && ($urandom_range(0, 2) == 0));
        end
        chk("drain_timeout", 32'(k < 500), 32'd1);
        cycle(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        #2 i_reset = 1'b1;
        #1;
        chk("rst_tx_start", 32'(o_tx_start), 32'd0);
        chk("rst_tx_data",  32'(o_tx_data),  32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        chk("rst_empty",    32'(o_empty),    32'd1);
        chk("rst_full",     32'(o_full),     32'd0);
        model_reset();
        i_data_ready = 1'b0;
        i_tx_done    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        #2 i_reset = 1'b0;
    endtask

    // Monitor: every start pulse must carry the oldest accepted byte.
    always @(negedge clk) begin
        if (!i_reset && o_tx_start) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_start", 32'(o_tx_data), 32'hFFFF_FFFF);
            end else begin
                chk("sb_tx_byte", 32'(o_tx_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        i_reset      = 1'b1;
        i_data_ready = 1'b0;
        i_data       = '0;
        i_tx_done    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        i_reset = 1'b0;

        // Single result with a slow transmitter
        cycle(1'b1, 8'h5A, 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Burst fill, sixth push dropped
        for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        drain();

        // Push on the pop edge while full
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(8'h10 * i + i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'hAA, 1'b0);
        drain();

        // Done pulses in IDLE (empty) and in START are ignored
        repeat (3) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0);
        drain();

        // Reset in WAIT with two bytes queued, then stray done and a fresh push
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        cycle(1'b0, '0, 1'b0);
        do_reset();
        cycle(1'b0, '0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0);
        drain();

        // Pointer wrap-around with sequential values
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(8'h10 + i), (m_ph == 2) && ($urandom_range(0, 1) == 0));
            if ($urandom_range(0, 2) == 0) cycle(1'b0, '0, m_ph == 2);
        end
        drain();

        // Random traffic, including stray done pulses outside WAIT
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) == 0, 8'($urandom),
                  (m_ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0));
        end
        drain();

        chk("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
